debug_scan_ctl: RTL

Debug-probe scan controller on `debug_clk`. It walks the tag's 16-way debug observation mux address (`probe_addr`) and samples the single-bit `probe_in` return through an internal synchronizer. Each scan assembles a 16-bit snapshot, then serializes it as a framed bitstream for the bench/logic-analyzer pin. It replaces the fixed debug address register and sequences that mux, either once per request or continuously.

---
 rtl/debug_scan_pkg.sv | 35 +++
 rtl/dbg_sync2.sv | 29 ++
 rtl/debug_scan_ctl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the debug-probe scan controller.
// DEBUG_SCAN_PARITY_EN appends an even-parity bit to every frame.
package debug_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_GAP    = 2'd3
  } scan_state_e;

  localparam logic [2:0] FRAME_HDR  = 3'b101;
  localparam int         HDR_LEN    = 3;
  localparam int         NUM_PROBES = 16;
  localparam int         ADDR_W     = 4;
  localparam int         BITCNT_W   = 5;

`ifdef DEBUG_SCAN_PARITY_EN
  localparam int PARITY_LEN = 1;
`else
  localparam int PARITY_LEN = 0;
`endif

  localparam int FRAME_LEN = HDR_LEN + NUM_PROBES + PARITY_LEN;

  // Whole frame, MSB transmitted first.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [NUM_PROBES-1:0] snap);
`ifdef DEBUG_SCAN_PARITY_EN
    return {FRAME_HDR, snap, ^snap};
`else
    return {FRAME_HDR, snap};
`endif
  endfunction

endpackage

// File: rtl/dbg_sync2.sv
// Two-flop synchronizer bringing the asynchronous probe return into debug_clk.
module dbg_sync2 (
  input  logic debug_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debug_scan_ctl.sv
// Walks the 16-way debug mux, captures a snapshot and serializes it as a framed bitstream.
// Frame length depends on DEBUG_SCAN_PARITY_EN (see debug_scan_pkg).
module debug_scan_ctl
  import debug_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int IDLE_GAP   = 4
) (
  input  logic                  debug_clk,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic                  scan_req,
  input  logic                  probe_in,
  output logic [ADDR_W-1:0]     probe_addr,
  output logic [NUM_PROBES-1:0] snapshot,
  output logic                  frame_out,
  output logic                  frame_valid,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun
);

  // One counter serves both the address dwell and the inter-frame gap.
  localparam int CNT_MAX = (SETTLE_CYC > IDLE_GAP) ? SETTLE_CYC : IDLE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]    GAP_LAST    = CNT_W'(IDLE_GAP - 1);
  localparam logic [ADDR_W-1:0]   ADDR_LAST   = ADDR_W'(NUM_PROBES - 1);
  localparam logic [BITCNT_W-1:0] FRAME_END   = BITCNT_W'(FRAME_LEN);

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_PROBES-1:0] cap_q, cap_d;
  logic [NUM_PROBES-1:0] snap_q, snap_d;
  logic [FRAME_LEN-1:0]  shreg_q, shreg_d;
  logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                  frame_out_q, frame_out_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic                  sync_out;
  logic [NUM_PROBES-1:0] cap_full;
  logic [FRAME_LEN-1:0]  frame_vec;

  dbg_sync2 u_probe_sync (
    .debug_clk (debug_clk),
    .reset     (reset),
    .d         (probe_in),
    .q         (sync_out)
  );

  // Capture register with the current address slot replaced by the live sample,
  // so the final capture edge can load the snapshot in one step.
  generate
    for (genvar gi = 0; gi < NUM_PROBES; gi++) begin : g_cap
      assign cap_full[gi] = (addr_q == ADDR_W'(gi)) ? sync_out : cap_q[gi];
    end
  endgenerate

  assign frame_vec = build_frame(cap_full);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    cap_d         = cap_q;
    snap_d        = snap_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    frame_out_d   = frame_out_q;
    frame_valid_d = frame_valid_q;
    frame_done_d  = 1'b0;
    busy_d        = busy_q;
    overrun_d     = overrun_q;

    if (scan_req && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (scan_req || scan_en) begin
          state_d = ST_SAMPLE;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      ST_SAMPLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cap_d = cap_full;
          cnt_d = '0;
          if (addr_q == ADDR_LAST) begin
            // Last address: publish the snapshot and put the first frame bit out now.
            snap_d        = cap_full;
            addr_d        = '0;
            state_d       = ST_SHIFT;
            frame_out_d   = frame_vec[FRAME_LEN-1];
            frame_valid_d = 1'b1;
            shreg_d       = frame_vec << 1;
            bit_cnt_d     = BITCNT_W'(1);
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q == FRAME_END) begin
          state_d       = ST_GAP;
          frame_out_d   = 1'b0;
          frame_valid_d = 1'b0;
          frame_done_d  = 1'b1;
          cnt_d         = '0;
        end else begin
          frame_out_d = shreg_q[FRAME_LEN-1];
          shreg_d     = shreg_q << 1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (scan_en) begin
            state_d = ST_SAMPLE;
            addr_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      cap_q         <= '0;
      snap_q        <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      frame_out_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      cap_q         <= cap_d;
      snap_q        <= snap_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_out_q   <= frame_out_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign probe_addr  = addr_q;
  assign snapshot    = snap_q;
  assign frame_out   = frame_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule
